// File: rtl/arm_instr_encoder_pkg.sv
// Shared codes, FSM state type and the legal-opcode check used by the
// ARM instruction encoder and its field packer.
package arm_enc_pkg;

    localparam logic [1:0] OpDp  = 2'b00;
    localparam logic [1:0] OpMem = 2'b01;
    localparam logic [1:0] OpBr  = 2'b10;
    localparam logic [1:0] OpIll = 2'b11;

    localparam logic [3:0] CmdAnd = 4'b0000;
    localparam logic [3:0] CmdSub = 4'b0010;
    localparam logic [3:0] CmdAdd = 4'b0100;
    localparam logic [3:0] CmdOrr = 4'b1100;
    localparam logic [3:0] CmdCmp = 4'b1010;
    localparam logic [3:0] CmdMov = 4'b1101;

    localparam logic [1:0] ShLsl = 2'b00;
    localparam logic [1:0] ShLsr = 2'b01;
    localparam logic [1:0] ShAsr = 2'b10;
    localparam logic [1:0] ShRor = 2'b11;

    localparam logic [1:0] SrcImm    = 2'b00;
    localparam logic [1:0] SrcRegImm = 2'b01;
    localparam logic [1:0] SrcRegReg = 2'b10;
    localparam logic [1:0] SrcIll    = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StLoad = 2'b01,
        StDone = 2'b10
    } state_e;

    function automatic logic is_legal_cmd(input logic [3:0] cmd);
        return (cmd == CmdAnd) || (cmd == CmdSub) || (cmd == CmdAdd) ||
               (cmd == CmdOrr) || (cmd == CmdCmp) || (cmd == CmdMov);
    endfunction

endpackage

// File: rtl/arm_instr_encoder_if.sv
// Request handshake, instruction-memory write bus and session status of the encoder.
interface arm_instr_encoder_if #(
    parameter int unsigned DEPTH = 64
);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic            start;
    logic            in_valid;
    logic            in_ready;
    logic            in_last;
    logic [1:0]      op_class;
    logic [3:0]      cond;
    logic [3:0]      cmd;
    logic            s_bit;
    logic            l_bit;
    logic            u_bit;
    logic [1:0]      src_mode;
    logic [3:0]      rn;
    logic [3:0]      rd;
    logic [3:0]      rm;
    logic [3:0]      rs;
    logic [1:0]      sh;
    logic [4:0]      shamt;
    logic [11:0]     imm12;
    logic [23:0]     imm24;
    logic            imem_we;
    logic [31:0]     imem_addr;
    logic [31:0]     imem_wd;
    logic            busy;
    logic            done;
    logic            err_illegal;
    logic            overflow;
    logic [CntW-1:0] word_count;

    modport master (
        output start, in_valid, in_last, op_class, cond, cmd, s_bit, l_bit, u_bit,
               src_mode, rn, rd, rm, rs, sh, shamt, imm12, imm24,
        input  in_ready, imem_we, imem_addr, imem_wd, busy, done, err_illegal,
               overflow, word_count
    );

    modport slave (
        input  start, in_valid, in_last, op_class, cond, cmd, s_bit, l_bit, u_bit,
               src_mode, rn, rd, rm, rs, sh, shamt, imm12, imm24,
        output in_ready, imem_we, imem_addr, imem_wd, busy, done, err_illegal,
               overflow, word_count
    );

endinterface

// File: rtl/arm_instr_encoder_field_pack.sv
// Combinational packer: instruction fields to a 32-bit ARM word, with the
// CMP/MOV field overrides and a flag for requests outside the supported subset.
module arm_field_pack
    import arm_enc_pkg::*;
(
    input  logic [1:0]  i_op_class,
    input  logic [3:0]  i_cond,
    input  logic [3:0]  i_cmd,
    input  logic        i_s_bit,
    input  logic        i_l_bit,
    input  logic        i_u_bit,
    input  logic [1:0]  i_src_mode,
    input  logic [3:0]  i_rn,
    input  logic [3:0]  i_rd,
    input  logic [3:0]  i_rm,
    input  logic [3:0]  i_rs,
    input  logic [1:0]  i_sh,
    input  logic [4:0]  i_shamt,
    input  logic [11:0] i_imm12,
    input  logic [23:0] i_imm24,
    output logic [31:0] o_word,
    output logic        o_illegal
);

    logic [11:0] w_shift_imm;
    logic [11:0] w_shift_reg;
    logic [11:0] w_dp_src2;
    logic [3:0]  w_dp_rn;
    logic [3:0]  w_dp_rd;
    logic        w_dp_s;

    assign w_shift_imm = {i_shamt, i_sh, 1'b0, i_rm};
    assign w_shift_reg = {i_rs, 1'b0, i_sh, 1'b1, i_rm};

    // CMP always sets flags and has no destination; MOV has no first operand.
    assign w_dp_s  = (i_cmd == CmdCmp) ? 1'b1 : i_s_bit;
    assign w_dp_rd = (i_cmd == CmdCmp) ? 4'd0 : i_rd;
    assign w_dp_rn = (i_cmd == CmdMov) ? 4'd0 : i_rn;

    always_comb begin
        w_dp_src2 = i_imm12;
        if (i_src_mode == SrcRegImm) begin
            w_dp_src2 = w_shift_imm;
        end else if (i_src_mode == SrcRegReg) begin
            w_dp_src2 = w_shift_reg;
        end
    end

    always_comb begin
        o_word    = '0;
        o_illegal = 1'b0;
        case (i_op_class)
            OpDp: begin
                o_word    = {i_cond, 2'b00, (i_src_mode == SrcImm), i_cmd, w_dp_s,
                             w_dp_rn, w_dp_rd, w_dp_src2};
                o_illegal = !is_legal_cmd(i_cmd) || (i_src_mode == SrcIll);
            end
            OpMem: begin
                // Pre-indexed, word access, no write-back.
                o_word    = {i_cond, 2'b01, (i_src_mode == SrcRegImm), 1'b1, i_u_bit,
                             1'b0, 1'b0, i_l_bit, i_rn, i_rd,
                             (i_src_mode == SrcRegImm) ? w_shift_imm : i_imm12};
                o_illegal = i_src_mode[1];
            end
            OpBr: begin
                o_word    = {i_cond, 3'b101, i_l_bit, i_imm24};
                o_illegal = (i_src_mode == SrcIll);
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/arm_instr_encoder.sv
// Program loader: accepts encoded-instruction requests and writes one ARM word
// per cycle to instruction memory at sequential addresses.
module arm_instr_encoder
    import arm_enc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 64
) (
    input  logic               i_clk,
    input  logic               i_reset,
    arm_instr_encoder_if.slave bus_if
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    state_e          r_state;
    state_e          w_state_next;
    logic            r_stop;
    logic            r_we;
    logic [31:0]     r_enc;
    logic [31:0]     r_addr;
    logic [CntW-1:0] r_count;
    logic [CntW-1:0] r_acc;
    logic            r_err;
    logic            r_ovf;

    logic            w_in_ready;
    logic            w_accept;
    logic            w_start_ok;
    logic            w_illegal;
    logic            w_hit_depth;
    logic [CntW-1:0] w_acc_inc;
    logic [31:0]     w_word;

    arm_field_pack u_field_pack (
        .i_op_class (bus_if.op_class),
        .i_cond     (bus_if.cond),
        .i_cmd      (bus_if.cmd),
        .i_s_bit    (bus_if.s_bit),
        .i_l_bit    (bus_if.l_bit),
        .i_u_bit    (bus_if.u_bit),
        .i_src_mode (bus_if.src_mode),
        .i_rn       (bus_if.rn),
        .i_rd       (bus_if.rd),
        .i_rm       (bus_if.rm),
        .i_rs       (bus_if.rs),
        .i_sh       (bus_if.sh),
        .i_shamt    (bus_if.shamt),
        .i_imm12    (bus_if.imm12),
        .i_imm24    (bus_if.imm24),
        .o_word     (w_word),
        .o_illegal  (w_illegal)
    );

    assign w_in_ready  = (r_state == StLoad) && !r_stop;
    assign w_accept    = bus_if.in_valid && w_in_ready;
    assign w_start_ok  = bus_if.start && (r_state != StLoad);
    assign w_acc_inc   = r_acc + 1'b1;
    // Only legal requests consume a slot of the session budget.
    assign w_hit_depth = !w_illegal && (w_acc_inc == CntW'(DEPTH));

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (bus_if.start) w_state_next = StLoad;
            end
            StLoad: begin
                // An illegal final request has nothing to write, so finish on acceptance.
                if (w_accept && w_illegal && bus_if.in_last) begin
                    w_state_next = StDone;
                end else if (r_we && r_stop) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                if (bus_if.start) w_state_next = StLoad;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        bus_if.in_ready    = w_in_ready;
        bus_if.imem_we     = r_we;
        bus_if.imem_addr   = r_addr;
        bus_if.imem_wd     = r_enc;
        bus_if.busy        = (r_state == StLoad);
        bus_if.done        = (r_state == StDone);
        bus_if.err_illegal = r_err;
        bus_if.overflow    = (r_state == StDone) && r_ovf;
        bus_if.word_count  = r_count;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_stop  <= 1'b0;
            r_we    <= 1'b0;
            r_enc   <= '0;
            r_addr  <= BASE_ADDR;
            r_count <= '0;
            r_acc   <= '0;
            r_err   <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_start_ok) begin
            r_stop  <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= BASE_ADDR;
            r_count <= '0;
            r_acc   <= '0;
            r_err   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (r_we) begin
                r_addr  <= r_addr + 32'd4;
                r_count <= r_count + 1'b1;
            end
            r_we <= w_accept && !w_illegal;
            if (w_accept) begin
                if (w_illegal) begin
                    r_err <= 1'b1;
                end else begin
                    r_enc <= w_word;
                    r_acc <= w_acc_inc;
                end
                if (bus_if.in_last || w_hit_depth) r_stop <= 1'b1;
                if (w_hit_depth && !bus_if.in_last) r_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: doc/arm_instr_encoder.md
Name: arm_instr_encoder

Overview:
- Inverse of the single-cycle control decoder: builds 32-bit ARM machine words from instruction fields and writes them to instruction memory.
- Covers exactly the subset the datapath executes: ADD, SUB, AND, ORR, CMP, MOV; LDR/STR with immediate or scaled-register offset; B/BL.
- Sits beside imem as a program loader for self-checking benches and boot-time loading. Takes requests over a valid/ready handshake and writes one word per cycle at sequential addresses.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first written word.
- DEPTH, 64, maximum words per load session (≥1).

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  pulse: opens a load session
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid&in_ready
- in_last  in  1  marks the final request of the session
- op_class  in  2  00 DP, 01 MEM, 10 BR, 11 illegal
- cond  in  4  condition field
- cmd  in  4  DP opcode; ignored for MEM/BR
- s_bit  in  1  DP set-flags
- l_bit  in  1  MEM: 1=LDR 0=STR; BR: 1=BL
- u_bit  in  1  MEM offset sign, 1=add
- src_mode  in  2  00 imm, 01 reg shift-imm, 10 reg shift-reg, 11 illegal
- rn, rd, rm, rs  in  4 each  register fields
- sh  in  2  shift type
- shamt  in  5  shift amount
- imm12  in  12  DP {rot4,imm8} or MEM offset
- imm24  in  24  branch word offset, passed through unchanged
- imem_we  out  1  write strobe
- imem_addr  out  32  byte address
- imem_wd  out  32  encoded word
- busy  out  1  state==LOAD
- done  out  1  session finished
- err_illegal  out  1  sticky: an illegal request was dropped
- overflow  out  1  session ended at DEPTH without in_last
- word_count  out  $clog2(DEPTH+1)  words written this session

Behaviour:
- Reset (reset==0 at an edge): state=IDLE; every output is 0; imem_addr=BASE_ADDR. A pending write is dropped.
- FSM states:
  - IDLE: start → LOAD; clears counters and flags; addr=BASE_ADDR.
  - LOAD: in_ready = ~stop_q.
  - DONE: done=1. start → LOAD with the same clearing as from IDLE.
  - start is ignored while in LOAD.
- Pipeline: a request accepted at edge N is encoded into enc_q. imem_we=1 with imem_wd=enc_q during cycle N+1. At edge N+1, addr+=4 and word_count+=1. Throughput is 1 word per cycle, and there is no backpressure from imem.
- DP encoding: {cond, 2'b00, I, cmd, S, rn, rd, src2}.
  - I=1 when src_mode=00, with src2=imm12.
  - src_mode=01: src2={shamt, sh, 1'b0, rm}.
  - src_mode=10: src2={rs, 1'b0, sh, 1'b1, rm}.
- DP overrides:
  - CMP (cmd 1010): S forced to 1, Rd forced to 0.
  - MOV (cmd 1101): Rn forced to 0.
- MEM encoding: {cond, 2'b01, I̅, P=1, u_bit, B=0, W=0, l_bit, rn, rd, src2}.
  - I̅=0 with src2=imm12 when src_mode=00.
  - I̅=1 with src2={shamt, sh, 1'b0, rm} when src_mode=01.
- BR encoding: {cond, 3'b101, l_bit, imm24}.
- Illegal requests:
  - Conditions: op_class=11; DP cmd outside {0100, 0010, 0000, 1100, 1010, 1101}; src_mode=11; MEM with src_mode=10.
  - The request is accepted and not written; addr and word_count are unchanged; err_illegal is set.
  - in_last on an illegal request still ends the session.
- Stop conditions: stop_q is set when a request with in_last is accepted, or when the DEPTH-th word is accepted.
  - The state enters DONE at the edge that completes the final write, or at the acceptance edge if the final request is illegal.
  - overflow=1 only when the session ended at DEPTH and in_last=0 on that request.
  - in_last together with the DEPTH-th word gives overflow=0.
- Address: imem_addr is a 32-bit modulo wrap. No range check beyond DEPTH.

Decomposition:
- Package arm_enc_pkg holds:
  - op_class codes, DP cmd codes (ADD/SUB/AND/ORR/CMP/MOV), sh codes, src_mode codes;
  - a state enum;
  - the legal-cmd check function.
- Sub-module arm_field_pack: a purely combinational field-to-word packer with overrides and an illegal flag. The top level owns the FSM, enc_q, counters and flags.

Test Plan:
- ADD R1,R2,#5, cond E, accepted at N → imem_we in cycle N+1, addr 0x0, wd 0xE2821005; word_count=1.
- SUBS R3,R4,R5,LSL R6 (src_mode 10) → wd 0xE0543615. CMP R0,#0 with s_bit=0, rd=7 → wd 0xE3500000 (S and Rd forced).
- LDR R1,[R2,#8] → 0xE5921008. STR R1,[R2,R3,LSL #2] (src_mode 01, shamt 2) → 0xE7821103.
- Back-to-back burst ADD, LDR, BL imm24=0x000010 with in_last on BL:
  - addrs 0x0/0x4/0x8 on consecutive cycles; third wd 0xEB000010;
  - in_ready=0 after the BL accept; done=1, word_count=3, overflow=0.
- Illegal cases: cmd 0001 (EOR), then op_class 11:
  - no imem_we; addr unchanged; err_illegal=1 and sticky;
  - a following legal request is still written at the same addr.
- DEPTH=2 without in_last:
  - two writes, then in_ready=0, done=1, overflow=1;
  - reset low mid-burst with one write pending → no write next cycle, all outputs 0, state IDLE.
